axil_master: RTL and testbench
==============================

AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI-Lite data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16: AXI-Lite byte address width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: write strobe width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  ADDR_WIDTH  byte address. cmd_wdata  in  DATA_WIDTH  write data. cmd_wstrb  in  STRB_WIDTH  byte enables.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-010 rsp_write  out  1  echo of the command type. rsp_rdata  out  DATA_WIDTH  read data (0 for writes). rsp_resp  out  2  bresp or rresp.
REQ-011 m_axil_aw{addr,prot,valid}/awready, m_axil_w{data,strb,valid}/wready, m_axil_b{resp,valid}/bready, m_axil_ar{addr,prot,valid}/arready, m_axil_r{data,resp,valid}/rready: standard AXI4-Lite initiator ports; widths as parameters, prot 3 bits, resp 2 bits.

Function
REQ-012 One transaction outstanding at a time; cmd_ready=1 only in IDLE.
REQ-013 FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
REQ-014 IDLE: on cmd_valid&&cmd_ready, register addr/data/strb/type; go to WRITE if cmd_write, else READ.
REQ-015 WRITE: awvalid and wvalid both assert in the cycle after acceptance; each deasserts independently the cycle after its own ready is sampled high; go to WRESP once both handshakes are done, including the case where both complete in the same cycle.
REQ-016 awvalid/wvalid, once high, stay high with stable payload until handshake; never depend combinationally on awready/wready.
REQ-017 WRESP: bready=1; on bvalid capture bresp, rdata=0, go to RESP.
REQ-018 READ: arvalid=1 with stable araddr until arready; then go to RDATA.
REQ-019 RDATA: rready=1; on rvalid capture rdata/rresp, go to RESP.
REQ-020 RESP: rsp_valid=1 with stable payload until rsp_ready; then go to IDLE.
REQ-021 bready/rready are 0 outside WRESP/RDATA; bvalid/rvalid arriving outside those states are ignored.
REQ-022 awprot=arprot=3'b000 constant; awaddr/araddr are the registered cmd_addr passed through unmodified.
REQ-023 Minimum latency, command accept to rsp_valid: 3 cycles with a zero-wait responder. A responder that registers its readys adds 1 cycle per channel.
REQ-024 SLVERR/DECERR responses are passed through on rsp_resp with no retry.
REQ-025 All AXI and rsp outputs are registered.

Reset
REQ-026 rst_n low: state=IDLE; all valid/ready outputs 0; cmd_ready goes to 1 after release; payload registers 0.
REQ-027 Reset asserted mid-transaction aborts it immediately; no rsp is produced for it.

Structure
REQ-028 Shared package axil_pkg holds the FSM state typedef, the RESP_OKAY/EXOKAY/SLVERR/DECERR constants, and the PROT_DEFAULT constant.
REQ-029 Single flat module with no sub-modules.
REQ-030 Target size 150-250 lines of RTL.

Verification
REQ-031 Write 0x12345678 to addr 0x0010 with strb 0xF against axil_ram -> ram word 4 = 0x12345678; rsp_write=1, rsp_resp=0.
REQ-032 Read addr 0x0010 after REQ-031 -> rsp_rdata=0x12345678, rsp_resp=0, rsp_write=0.
REQ-033 Write 0xAABBCCDD with strb 0x3 over 0x11111111 -> read returns 0x1111CCDD.
REQ-034 Responder delays awready by 3 cycles and wready by 0 cycles -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one rsp is produced.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout; after release, the next command is accepted 1 cycle later.
REQ-036 rst_n pulsed low during RDATA -> all valids 0 asynchronously, no rsp produced; a new read after reset completes correctly.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the command-to-AXI-Lite master.
// Holds the FSM state type, response codes and the default protection value.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding bridge from a simple cmd/rsp handshake to an AXI4-Lite initiator port.
// Latency: 3 cycles from cmd accept to rsp_valid with a zero-wait responder; each ready wait adds cycles.
// Backpressure: cmd_ready only in IDLE; rsp_valid and its payload hold until rsp_ready.
module axil_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  write_q;

    logic cmd_fire;
    logic aw_done;
    logic w_done;

    assign cmd_fire = cmd_valid && cmd_ready;
    // A channel counts as done once its valid has dropped or its handshake is happening now.
    assign aw_done  = !m_axil_awvalid || m_axil_awready;
    assign w_done   = !m_axil_wvalid || m_axil_wready;

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign m_axil_awprot = PROT_DEFAULT;
    assign m_axil_arprot = PROT_DEFAULT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire)              state_next = cmd_write ? WRITE : READ;
            WRITE:   if (aw_done && w_done)     state_next = WRESP;
            WRESP:   if (m_axil_bvalid)         state_next = RESP;
            READ:    if (m_axil_arready)        state_next = RDATA;
            RDATA:   if (m_axil_rvalid)         state_next = RESP;
            RESP:    if (rsp_ready)             state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Every handshake output is a flop loaded from the next state, so none depends on a ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready      <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            write_q        <= 1'b0;
        end else begin
            cmd_ready      <= (state_next == IDLE);
            m_axil_awvalid <= (cmd_fire && cmd_write) || (m_axil_awvalid && !m_axil_awready);
            m_axil_wvalid  <= (cmd_fire && cmd_write) || (m_axil_wvalid && !m_axil_wready);
            m_axil_arvalid <= (state_next == READ);
            m_axil_bready  <= (state_next == WRESP);
            m_axil_rready  <= (state_next == RDATA);
            rsp_valid      <= (state_next == RESP);

            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
            end

            if (state == WRESP && m_axil_bvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= '0;
                rsp_resp  <= m_axil_bresp;
            end

            if (state == RDATA && m_axil_rvalid) begin
                rsp_write <= write_q;
                rsp_rdata <= m_axil_rdata;
                rsp_resp  <= m_axil_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Randomised bench for axil_master: behavioural AXI-Lite RAM responder plus a word-level memory model.
// Responder ready/data delays are adjustable per scenario to exercise stalls and reset aborts.
module tb_axil_master;
    import axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;

    axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    // ---------------- responder: 64-word RAM, cleared by reset ----------------
    int         aw_delay = 0;
    int         w_delay  = 0;
    int         r_delay  = 0;
    logic [1:0] inj_resp = RESP_OKAY;

    logic [31:0] ram [0:63];
    int          aw_cnt, w_cnt, r_cnt;
    logic        aw_got, w_got, r_pend;
    logic [AW-1:0] aw_lat, r_addr_lat, wr_addr;
    logic [DW-1:0] wd_lat, wr_data;
    logic [SW-1:0] ws_lat, wr_strb;
    logic        aw_hs, w_hs;

    assign awready = (aw_delay == 0) || (awvalid && aw_cnt >= aw_delay);
    assign wready  = (w_delay == 0)  || (wvalid && w_cnt >= w_delay);
    assign arready = 1'b1;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign wr_addr = aw_hs ? awaddr : aw_lat;
    assign wr_data = w_hs ? wdata : wd_lat;
    assign wr_strb = w_hs ? wstrb : ws_lat;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rresp <= '0; rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            aw_lat <= '0; wd_lat <= '0; ws_lat <= '0; r_addr_lat <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_lat <= awaddr; end
            if (w_hs)  begin w_got <= 1'b1; wd_lat <= wdata; ws_lat <= wstrb; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                ram[wr_addr[7:2]] <= byte_merge(ram[wr_addr[7:2]], wr_data, wr_strb);
                bvalid <= 1'b1;
                bresp  <= inj_resp;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_delay == 0) begin
                    rvalid <= 1'b1; rdata <= ram[araddr[7:2]]; rresp <= inj_resp;
                end else begin
                    r_pend <= 1'b1; r_cnt <= r_delay - 1; r_addr_lat <= araddr;
                end
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    r_pend <= 1'b0; rvalid <= 1'b1; rdata <= ram[r_addr_lat[7:2]]; rresp <= inj_resp;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- reference model and bookkeeping ----------------
    logic [31:0] ref_mem [0:63];
    int vectors = 0;
    int miscompares = 0;

    int          lat, aw_hi, w_hi;
    logic        ok;
    logic        got_write;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    logic [AW-1:0] addr_seen;
    logic [2:0]  prot_seen;

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~mask) | (d & mask);
    endtask

    // Issues one command and waits for rsp_valid; lat counts cycles with the accept cycle as 0.
    task automatic run_cmd(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        addr_seen = w ? awaddr : araddr;
        prot_seen = w ? awprot : arprot;
        lat = 1; aw_hi = 0; w_hi = 0;
        while (!rsp_valid && lat < 100) begin
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            @(negedge clk);
            lat++;
        end
        ok = ok && rsp_valid;
        got_write = rsp_write; got_rdata = rsp_rdata; got_resp = rsp_resp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: outputs=%b expected 0000000", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        end
        vectors++;
        if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: awaddr=%h wdata=%h rsp_rdata=%h expected zeros", awaddr, wdata, rsp_rdata);
        end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: cmd_ready=%b expected 1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        run_cmd(1'b1, 16'h0010, 32'h12345678, 4'hF);
        @(negedge clk);
        model_write(16'h0010, 32'h12345678, 4'hF);
        vectors++;
        if (!ok || got_write !== 1'b1 || got_resp !== 2'd0 || lat != 3) begin
            miscompares++;
            $display("FAIL wr_basic: ok=%b write=%b resp=%0d lat=%0d expected 1/1/0/3", ok, got_write, got_resp, lat);
        end
        vectors++;
        if (ram[4] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL ram_word4: got %h expected 12345678", ram[4]);
        end
        run_cmd(1'b0, 16'h0010, '0, '0);
        @(negedge clk);
        vectors++;
        if (!ok || got_rdata !== 32'h12345678 || got_resp !== 2'd0 || got_write !== 1'b0 || lat != 3) begin
            miscompares++;
            $display("FAIL rd_basic: rdata=%h resp=%0d write=%b lat=%0d expected 12345678/0/0/3", got_rdata, got_resp, got_write, lat);
        end
        run_cmd(1'b1, 16'h0020, 32'h11111111, 4'hF);
        @(negedge clk);
        run_cmd(1'b1, 16'h0020, 32'hAABBCCDD, 4'h3);
        @(negedge clk);
        run_cmd(1'b0, 16'h0020, '0, '0);
        @(negedge clk);
        model_write(16'h0020, 32'h11111111, 4'hF);
        model_write(16'h0020, 32'hAABBCCDD, 4'h3);
        vectors++;
        if (got_rdata !== 32'h1111CCDD) begin
            miscompares++;
            $display("FAIL rd_strobe: rdata=%h expected 1111ccdd", got_rdata);
        end
    endtask

    task automatic test_aw_delay();
        int extra;
        aw_delay = 3;
        run_cmd(1'b1, 16'h0044, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        model_write(16'h0044, 32'hCAFEF00D, 4'hF);
        vectors++;
        if (aw_hi != 4 || w_hi != 1 || lat != 6) begin
            miscompares++;
            $display("FAIL aw_delay_timing: aw_hi=%0d w_hi=%0d lat=%0d expected 4/1/6", aw_hi, w_hi, lat);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) extra++;
            @(negedge clk);
        end
        vectors++;
        if (extra != 0 || ram[17] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL aw_delay_single: extra_rsp=%0d ram=%h expected 0/cafef00d", extra, ram[17]);
        end
        aw_delay = 0;
    endtask

    task automatic test_rsp_stall();
        logic [31:0] exp;
        int n;
        exp = ref_mem[4];
        rsp_ready = 1'b0;
        run_cmd(1'b0, 16'h0010, '0, '0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 32'h0BADBEEF; cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_write !== 1'b0 || rsp_resp !== 2'd0 || cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: cyc=%0d valid=%b rdata=%h cmd_ready=%b expected 1/%h/0", i, rsp_valid, rsp_rdata, cmd_ready, exp);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: rsp_valid=%b cmd_ready=%b awvalid=%b expected 0/1/0", rsp_valid, cmd_ready, awvalid);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_next_accept: awvalid=%b wvalid=%b cmd_ready=%b expected 1/1/0", awvalid, wvalid, cmd_ready);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_resp !== 2'd0) begin
            miscompares++;
            $display("FAIL stall_next_rsp: valid=%b write=%b resp=%0d expected 1/1/0", rsp_valid, rsp_write, rsp_resp);
        end
        @(negedge clk);
        model_write(16'h0050, 32'h0BADBEEF, 4'hF);
    endtask

    task automatic test_random();
        logic        w;
        logic [15:0] a;
        logic [31:0] d, exp_d;
        logic [3:0]  s;
        logic [1:0]  er;
        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            a  = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            er = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : RESP_OKAY;
            inj_resp = er;
            exp_d = w ? 32'h0 : ref_mem[a[7:2]];
            run_cmd(w, a, d, s);
            @(negedge clk);
            if (w) model_write(a, d, s);
            vectors++;
            if (!ok || got_write !== w || got_rdata !== exp_d || got_resp !== er || lat != 3) begin
                miscompares++;
                $display("FAIL rand_txn %0d: ok=%b write=%b rdata=%h resp=%0d lat=%0d expected %b/%h/%0d/3",
                         t, ok, got_write, got_rdata, got_resp, lat, w, exp_d, er);
            end
            vectors++;
            if (addr_seen !== a || prot_seen !== PROT_DEFAULT) begin
                miscompares++;
                $display("FAIL rand_addr %0d: addr=%h prot=%0d expected %h/0", t, addr_seen, prot_seen, a);
            end
        end
        inj_resp = RESP_OKAY;
    endtask

    task automatic test_reset_abort();
        int n, stray;
        r_delay = 6;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (rready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_reach_rdata: rready=%b expected 1", rready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL abort_async: outputs=%b expected 0000000", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        end
        model_clear();
        r_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) stray++;
            @(negedge clk);
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL abort_no_rsp: stray=%0d expected 0", stray);
        end
        run_cmd(1'b1, 16'h0030, 32'h5A5AA5A5, 4'hF);
        @(negedge clk);
        model_write(16'h0030, 32'h5A5AA5A5, 4'hF);
        run_cmd(1'b0, 16'h0030, '0, '0);
        @(negedge clk);
        vectors++;
        if (!ok || got_rdata !== ref_mem[12] || got_resp !== 2'd0 || lat != 3) begin
            miscompares++;
            $display("FAIL abort_recover: rdata=%h resp=%0d lat=%0d expected %h/0/3", got_rdata, got_resp, lat, ref_mem[12]);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_directed();
        test_rsp_stall();
        test_aw_delay();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
